// File: rtl/adder_pipe_if.sv
// adder_pipe_if: operand stream (in_*) and result stream (out_*) of adder_pipe.
// The master side produces operands and consumes results; the adder is the slave.
interface adder_pipe_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/adder_pipe.sv
// adder_pipe: pipelined two's-complement adder/subtractor with valid/ready streams.
// The operand is cut into STAGES slices of W = WIDTH/STAGES bits; stage k adds
// slice k with the carry registered by stage k-1. Each slice adder is a
// carry-lookahead over 4-bit groups, with any narrower remainder rippled.
// Operand bits not yet consumed travel down the pipe with their beat, and the
// finished result slices accumulate alongside, so a beat always stays aligned.
// All stages advance together whenever the output register is empty or drained.
// Optional build macro: ADDER_PIPE_SAT_EN enables signed saturation of sum on
// overflow in the last stage (ovf and cout are still reported unmodified).
// The WIDTH parameter must match the WIDTH of the connected adder_pipe_if.
module adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  adder_pipe_if.slave bus
);
  localparam int W  = WIDTH / STAGES;
  localparam int NG = W / 4;
  localparam int R  = W % 4;

  logic             adv;
  logic             out_valid;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Subtraction is A + ~B + ~cin; carry-in of the lowest slice is sub ^ cin.
  assign b_eff        = bus.sub ? ~bus.b : bus.b;
  assign c0           = bus.sub ^ bus.cin;
  assign adv          = !out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar gi = 0; gi < STAGES; gi++) begin : stg
    localparam int SW = (gi + 1) * W;   // result bits finished after this stage
    localparam int UW = WIDTH - SW;     // operand bits still to be added

    logic [W-1:0]  x, y, g, p, s;
    logic          ci, vin, co;
    logic [NG:0]   gc;
    logic [SW-1:0] sum_cat, sum_next;
    logic          valid_reg, carry_reg;
    logic [SW-1:0] sum_reg;

    if (gi == 0) begin : g_src
      assign x       = bus.a[W-1:0];
      assign y       = b_eff[W-1:0];
      assign ci      = c0;
      assign vin     = bus.in_valid;
      assign sum_cat = s;
    end else begin : g_src
      assign x       = stg[gi-1].g_fwd.a_reg[W-1:0];
      assign y       = stg[gi-1].g_fwd.b_reg[W-1:0];
      assign ci      = stg[gi-1].carry_reg;
      assign vin     = stg[gi-1].valid_reg;
      assign sum_cat = {s, stg[gi-1].sum_reg};
    end

    assign g     = x & y;
    assign p     = x ^ y;
    assign gc[0] = ci;

    for (genvar gj = 0; gj < NG; gj++) begin : g_cla
      localparam int B = 4 * gj;
      logic [4:0] c;
      assign c[0] = gc[gj];
      assign c[1] = g[B] | (p[B] & c[0]);
      assign c[2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[0]);
      assign c[3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | ((&p[B+2:B]) & c[0]);
      assign c[4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                  | ((&p[B+3:B+1]) & g[B]) | ((&p[B+3:B]) & c[0]);
      assign s[B+3:B]  = p[B+3:B] ^ c[3:0];
      assign gc[gj+1]  = c[4];
    end

    if (R > 0) begin : g_rip
      logic [R:0] rc;
      assign rc[0] = gc[NG];
      for (genvar gk = 0; gk < R; gk++) begin : g_bit
        assign s[4*NG+gk] = p[4*NG+gk] ^ rc[gk];
        assign rc[gk+1]   = g[4*NG+gk] | (p[4*NG+gk] & rc[gk]);
      end
      assign co = rc[R];
    end else begin : g_norip
      assign co = gc[NG];
    end

    // Stage register: shift on global advance; data only reloads for a real beat.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_reg <= 1'b0;
        carry_reg <= 1'b0;
        sum_reg   <= '0;
      end else if (adv) begin
        valid_reg <= vin;
        if (vin) begin
          carry_reg <= co;
          sum_reg   <= sum_next;
        end
      end
    end

    if (gi < STAGES - 1) begin : g_fwd
      logic [UW-1:0] a_reg, b_reg, a_nxt, b_nxt;

      if (gi == 0) begin : g_hi
        assign a_nxt = bus.a[WIDTH-1:W];
        assign b_nxt = b_eff[WIDTH-1:W];
      end else begin : g_hi
        assign a_nxt = stg[gi-1].g_fwd.a_reg[WIDTH-gi*W-1:W];
        assign b_nxt = stg[gi-1].g_fwd.b_reg[WIDTH-gi*W-1:W];
      end

      assign sum_next = sum_cat;

      // Carry the not-yet-added operand slices along with their beat.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_reg <= '0;
          b_reg <= '0;
        end else if (adv && vin) begin
          a_reg <= a_nxt;
          b_reg <= b_nxt;
        end
      end
    end else begin : g_last
      logic ovf_next, ovf_reg;

      // Signed overflow: operands agree in sign but the result does not.
      assign ovf_next = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);

`ifdef ADDER_PIPE_SAT_EN
      assign sum_next = ovf_next ? {x[W-1], {(SW-1){~x[W-1]}}} : sum_cat;
`else
      assign sum_next = sum_cat;
`endif

      // Overflow flag travels with the finished result.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_reg <= 1'b0;
        end else if (adv && vin) begin
          ovf_reg <= ovf_next;
        end
      end
    end
  end

  assign out_valid     = stg[STAGES-1].valid_reg;
  assign bus.out_valid = out_valid;
  assign bus.sum       = stg[STAGES-1].sum_reg;
  assign bus.cout      = stg[STAGES-1].carry_reg;
  assign bus.ovf       = stg[STAGES-1].g_last.ovf_reg;
endmodule
